// File: rtl/colour_pkg.sv
// ============================================================================
// Module   : colour_pkg
// Purpose  : Shared TCS3200 colour-path types, filter codes and default sizing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package colour_pkg;

  typedef enum logic [1:0] {
    CH_RED   = 2'd0,
    CH_GREEN = 2'd1,
    CH_BLUE  = 2'd2,
    CH_CLEAR = 2'd3
  } channel_e;

  // {s2,s3} photodiode filter select codes
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_GATE   = 3'd2,
    ST_STORE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_GATE_CYC   = 50000;
  localparam int DEF_SETTLE_CYC = 5000;

  function automatic logic [1:0] filter_code(input channel_e ch);
    case (ch)
      CH_GREEN: filter_code = FILT_GREEN;
      CH_BLUE:  filter_code = FILT_BLUE;
      CH_CLEAR: filter_code = FILT_CLEAR;
      default:  filter_code = FILT_RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_edge_counter.sv
// ============================================================================
// Module   : freq_edge_counter
// Purpose  : Synchronises colour_freq, detects rising edges, counts them with saturation.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             colour_freq,
  input  logic             clr,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             saturated
);

  logic [2:0] sync;
  logic       rise;

  // sync[1:0] is the two-flop synchroniser, sync[2] the edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 3'b000;
    end else begin
      sync <= {sync[1:0], colour_freq};
    end
  end

  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      saturated <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      saturated <= 1'b0;
    end else if (enable && rise) begin
      if (count == {CNT_W{1'b1}}) begin
        saturated <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/colour_filter_sequencer.sv
// ============================================================================
// Module   : colour_filter_sequencer
// Purpose  : Steps the TCS3200 through its filters and emits one RGB(+C) count frame.
//            Define CLEAR_CHANNEL_EN to add the CLEAR channel and clear_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module colour_filter_sequencer
  import colour_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GATE_CYC   = DEF_GATE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             colour_freq,
  output logic             s2,
  output logic             s3,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt,
  output logic [CNT_W-1:0] blue_cnt,
  output logic             meas_valid,
  output logic             sat,
  output logic             busy
`ifdef CLEAR_CHANNEL_EN
  ,output logic [CNT_W-1:0] clear_cnt
`endif
);

`ifdef CLEAR_CHANNEL_EN
  localparam channel_e LAST_CH = CH_CLEAR;
`else
  localparam channel_e LAST_CH = CH_BLUE;
`endif

  localparam int MAX_CYC = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  state_e           state_q, state_d;
  channel_e         ch_q, ch_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [CNT_W-1:0] count;
  logic             saturated;
  logic             frame_end;
  logic [CNT_W-1:0] shadow_red, shadow_green;
`ifdef CLEAR_CHANNEL_EN
  logic [CNT_W-1:0] shadow_blue;
`endif
  logic             sat_frame;

  freq_edge_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .colour_freq (colour_freq),
    .clr         (state_q == ST_SETTLE),
    .enable      (state_q == ST_GATE),
    .count       (count),
    .saturated   (saturated)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ch_q    <= CH_RED;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        ch_d    = CH_RED;
        timer_d = '0;
        if (en) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!en) begin
          state_d = ST_IDLE;
          ch_d    = CH_RED;
          timer_d = '0;
        end else if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
          state_d = ST_GATE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GATE: begin
        if (!en) begin
          state_d = ST_IDLE;
          ch_d    = CH_RED;
          timer_d = '0;
        end else if (timer_q == TMR_W'(GATE_CYC - 1)) begin
          state_d = ST_STORE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_STORE: begin
        timer_d = '0;
        if (ch_q == LAST_CH) begin
          state_d = ST_DONE;
          ch_d    = CH_RED;
        end else begin
          state_d = ST_SETTLE;
          ch_d    = channel_e'(ch_q + 2'd1);
        end
      end
      ST_DONE: begin
        timer_d = '0;
        state_d = en ? ST_SETTLE : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = CH_RED;
        timer_d = '0;
      end
    endcase
  end

  // Outputs load on the last STORE edge so they are visible during DONE
  assign frame_end = (state_q == ST_STORE) && (ch_q == LAST_CH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_red   <= '0;
      shadow_green <= '0;
`ifdef CLEAR_CHANNEL_EN
      shadow_blue  <= '0;
      clear_cnt    <= '0;
`endif
      sat_frame    <= 1'b0;
      red_cnt      <= '0;
      green_cnt    <= '0;
      blue_cnt     <= '0;
      sat          <= 1'b0;
      meas_valid   <= 1'b0;
    end else begin
      meas_valid <= frame_end;
      if (state_q == ST_IDLE || state_q == ST_DONE) begin
        sat_frame <= 1'b0;
      end
      if (state_q == ST_STORE) begin
        sat_frame <= sat_frame | saturated;
        case (ch_q)
          CH_RED:   shadow_red   <= count;
          CH_GREEN: shadow_green <= count;
`ifdef CLEAR_CHANNEL_EN
          CH_BLUE:  shadow_blue  <= count;
`endif
          default: ;
        endcase
      end
      if (frame_end) begin
        red_cnt   <= shadow_red;
        green_cnt <= shadow_green;
`ifdef CLEAR_CHANNEL_EN
        blue_cnt  <= shadow_blue;
        clear_cnt <= count;
`else
        blue_cnt  <= count;
`endif
        sat       <= sat_frame | saturated;
      end
    end
  end

  assign {s2, s3} = filter_code(ch_q);
  assign busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_colour_filter_sequencer.sv
// ============================================================================
// Module   : tb_colour_filter_sequencer
// Purpose  : Directed self-checking bench; honours CLEAR_CHANNEL_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_colour_filter_sequencer;

  localparam int GATE   = 100;
  localparam int SETTLE = 10;
`ifdef CLEAR_CHANNEL_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 3;
`endif
  localparam int FRAME = NCH * (SETTLE + GATE + 1) + 1;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, colour_freq = 1'b0;

  logic       s2, s3, meas_valid, sat, busy;
  logic [7:0] red_cnt, green_cnt, blue_cnt;
  logic       s2_4, s3_4, meas_valid4, sat4, busy4;
  logic [3:0] red4, green4, blue4;
`ifdef CLEAR_CHANNEL_EN
  logic [7:0] clear_cnt;
  logic [3:0] clear4;
`endif

  colour_filter_sequencer #(.CNT_W(8), .GATE_CYC(GATE), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .colour_freq(colour_freq),
    .s2(s2), .s3(s3), .red_cnt(red_cnt), .green_cnt(green_cnt), .blue_cnt(blue_cnt),
    .meas_valid(meas_valid), .sat(sat), .busy(busy)
`ifdef CLEAR_CHANNEL_EN
    , .clear_cnt(clear_cnt)
`endif
  );

  colour_filter_sequencer #(.CNT_W(4), .GATE_CYC(GATE), .SETTLE_CYC(SETTLE)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .colour_freq(colour_freq),
    .s2(s2_4), .s3(s3_4), .red_cnt(red4), .green_cnt(green4), .blue_cnt(blue4),
    .meas_valid(meas_valid4), .sat(sat4), .busy(busy4)
`ifdef CLEAR_CHANNEL_EN
    , .clear_cnt(clear4)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int per_r = 10, per_g = 20, per_b = 25, per_c = 10;
  int phase = 0;

  // Sensor model: square wave whose period follows the selected filter
  initial begin
    int p;
    forever begin
      @(negedge clk);
      phase++;
      case ({s2, s3})
        2'b00:   p = per_r;
        2'b11:   p = per_g;
        2'b01:   p = per_b;
        default: p = per_c;
      endcase
      colour_freq = ((phase % p) < (p / 2));
    end
  end

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic wait_valid(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n++;
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int clip4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic int tol4(input int v);
    return (v > 15) ? 0 : 1;
  endfunction

  typedef struct {
    int pr, pg, pb, pc;
    int er, eg, eb, ec;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int        n;
    bit        ok;
    int        ncodes;
    int        pulses;
    logic [1:0] prev;
    logic [1:0] codes   [8];
    logic [1:0] exp_seq [4];
    bit        exp_sat4;

    tbl[0] = '{pr: 10, pg: 20, pb: 25,  pc: 10, er: 10, eg: 5,  eb: 4,  ec: 10};
    tbl[1] = '{pr: 5,  pg: 10, pb: 50,  pc: 10, er: 20, eg: 10, eb: 2,  ec: 10};
    tbl[2] = '{pr: 4,  pg: 4,  pb: 4,   pc: 4,  er: 25, eg: 25, eb: 25, ec: 25};
    tbl[3] = '{pr: 2,  pg: 50, pb: 100, pc: 10, er: 50, eg: 2,  eb: 1,  ec: 10};
`ifdef CLEAR_CHANNEL_EN
    exp_seq = '{2'b11, 2'b01, 2'b10, 2'b00};
`else
    exp_seq = '{2'b11, 2'b01, 2'b00, 2'b00};
`endif

    repeat (3) @(negedge clk);
    chk("reset_red", int'(red_cnt), 0, 0);
    chk("reset_valid", int'(meas_valid), 0, 0);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_s2s3", int'({s2, s3}), 0, 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("run_busy", int'(busy), 1, 0);
    chk("run_s2s3_red", int'({s2, s3}), 0, 0);

    // First frame: log every filter-code change up to meas_valid
    prev   = 2'b00;
    ncodes = 0;
    ok     = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ({s2, s3} != prev) begin
        if (ncodes < 8) codes[ncodes] = {s2, s3};
        ncodes++;
        prev = {s2, s3};
      end
      if (meas_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("first_frame_timeout", int'(ok), 1, 0);
    chk("code_changes", ncodes, NCH, 0);
    for (int i = 0; i < NCH; i++) begin
      if (i < ncodes) chk($sformatf("code_seq[%0d]", i), int'(codes[i]), int'(exp_seq[i]), 0);
    end

    for (int k = 0; k < 4; k++) begin
      per_r = tbl[k].pr;
      per_g = tbl[k].pg;
      per_b = tbl[k].pb;
      per_c = tbl[k].pc;
      @(negedge clk);
      chk($sformatf("v%0d_pulse_width", k), int'(meas_valid), 0, 0);
      wait_valid(n, ok);
      chk($sformatf("v%0d_timeout", k), int'(ok), 1, 0);
      chk($sformatf("v%0d_period", k), n + 1, FRAME, 0);
      chk($sformatf("v%0d_red", k), int'(red_cnt), tbl[k].er, 1);
      chk($sformatf("v%0d_green", k), int'(green_cnt), tbl[k].eg, 1);
      chk($sformatf("v%0d_blue", k), int'(blue_cnt), tbl[k].eb, 1);
      chk($sformatf("v%0d_sat", k), int'(sat), 0, 0);
      chk($sformatf("v%0d_valid4", k), int'(meas_valid4), 1, 0);
      chk($sformatf("v%0d_red4", k), int'(red4), clip4(tbl[k].er), tol4(tbl[k].er));
      chk($sformatf("v%0d_green4", k), int'(green4), clip4(tbl[k].eg), tol4(tbl[k].eg));
      chk($sformatf("v%0d_blue4", k), int'(blue4), clip4(tbl[k].eb), tol4(tbl[k].eb));
      exp_sat4 = (tbl[k].er > 15) || (tbl[k].eg > 15) || (tbl[k].eb > 15);
`ifdef CLEAR_CHANNEL_EN
      chk($sformatf("v%0d_clear", k), int'(clear_cnt), tbl[k].ec, 1);
      chk($sformatf("v%0d_clear4", k), int'(clear4), clip4(tbl[k].ec), tol4(tbl[k].ec));
      exp_sat4 = exp_sat4 || (tbl[k].ec > 15);
`endif
      chk($sformatf("v%0d_sat4", k), int'(sat4), int'(exp_sat4), 0);
    end

    // Abort mid-GREEN gate: outputs must keep the last table frame
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ({s2, s3} == 2'b11) begin
        ok = 1'b1;
        break;
      end
    end
    chk("green_reach_timeout", int'(ok), 1, 0);
    repeat (60) @(negedge clk);
    chk("abort_pre_busy", int'(busy), 1, 0);
    chk("abort_pre_s2s3", int'({s2, s3}), 3, 0);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_s2s3", int'({s2, s3}), 0, 0);
    pulses = 0;
    repeat (400) begin
      @(negedge clk);
      if (meas_valid) pulses++;
    end
    chk("abort_no_valid", pulses, 0, 0);
    chk("abort_keep_red", int'(red_cnt), tbl[3].er, 1);
    chk("abort_keep_green", int'(green_cnt), tbl[3].eg, 1);
    chk("abort_keep_blue", int'(blue_cnt), tbl[3].eb, 1);

    // Asynchronous reset mid-frame
    en = 1'b1;
    repeat (150) @(negedge clk);
    chk("rerun_busy", int'(busy), 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_red", int'(red_cnt), 0, 0);
    chk("async_green", int'(green_cnt), 0, 0);
    chk("async_busy", int'(busy), 0, 0);
    chk("async_s2s3", int'({s2, s3}), 0, 0);
    chk("async_valid", int'(meas_valid), 0, 0);
    chk("async_red4", int'(red4), 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
